branch_predictor: RTL and testbench

Dynamic branch predictor serving the fetch stage and trained by the execute stage. Fetch presents its PC and receives a same-cycle taken/not-taken prediction plus target. These come from a direct-mapped table of 2-bit saturating counters and a tagged branch target buffer (BTB). Execute returns the resolved outcome of every conditional branch, which updates the tables on the next clock edge. Branch and mispredict totals are kept in saturating performance counters.

---
 rtl/branch_predictor.sv | 95 +++++++++
 tb/tb_branch_predictor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table plus tagged BTB,
// trained by execute one edge after resolution, with saturating branch/mispredict totals.
module branch_predictor #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  output logic [31:0]       br_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0]        ctr_q    [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [31:0]       br_cnt_q, br_cnt_d;
  logic [31:0]       mis_cnt_q, mis_cnt_d;
  logic [1:0]        ctr_d;

  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [TAG_W-1:0]  rd_tag, wr_tag;
  logic              hit;
  logic              unused_pc_bits;

  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign rd_idx = if_pc[IDX_W+1:2];
  assign rd_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign wr_idx = upd_pc[IDX_W+1:2];
  assign wr_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = ^upd_pc[1:0];

  // Lookup reads registered state only, so a same-cycle update is never bypassed.
  assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken  = hit && ctr_q[rd_idx][1];
  assign pred_target = pred_taken ? target_q[rd_idx] : if_pc + ADDR_W'(4);

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;

  always_comb begin
    ctr_d     = sat_ctr(ctr_q[wr_idx], upd_taken);
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_en) begin
      br_cnt_d = sat_inc32(br_cnt_q);
      if (upd_mispred) mis_cnt_d = sat_inc32(mis_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      valid_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      if (upd_en) begin
        ctr_q[wr_idx] <= ctr_d;
        // Taken branches claim the BTB slot even if another PC owned it; counter is shared.
        if (upd_taken) begin
          valid_q[wr_idx]  <= 1'b1;
          tag_q[wr_idx]    <= wr_tag;
          target_q[wr_idx] <= upd_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued as stimulus is
// applied and drained against the DUT outputs half a cycle after each edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum int {K_PT, K_TGT, K_BR, K_MIS} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  branch_predictor #(.IDX_W(4), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_pc       (if_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input kind_t k, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.kind = k; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.kind)
        K_PT:    obs = {31'd0, pred_taken};
        K_TGT:   obs = pred_target;
        K_BR:    obs = br_cnt;
        default: obs = mispred_cnt;
      endcase
      chk(x.tag, obs, x.exp);
    end
  endtask

  // Set if_pc in the low phase, let it settle, then compare prediction.
  task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    if_pc = pc;
    #1;
    push({tag, ".pt"}, K_PT, {31'd0, pt});
    push({tag, ".tgt"}, K_TGT, tgt);
    drain();
  endtask

  task automatic cnts(input string tag, input logic [31:0] br, input logic [31:0] mis);
    #1;
    push({tag, ".br"}, K_BR, br);
    push({tag, ".mis"}, K_MIS, mis);
    drain();
  endtask

  // Called at a negedge; returns at the following negedge with upd_en dropped.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
    upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispred = mis; upd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    upd_en = 1'b0;
    upd_pc = 32'hDEAD_BEEF; upd_taken = 1'b1; upd_target = 32'h1234_5678; upd_mispred = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h0; upd_en = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_mispred = 1'b0;
    // Prediction during reset
    #1;
    look("in_reset", 32'h0000_0010, 1'b0, 32'h0000_0014);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    look("rst", 32'h0000_0010, 1'b0, 32'h0000_0014);
    cnts("rst", 32'd0, 32'd0);

    upd(32'h0000_0010, 1'b1, 32'h0000_0100, 1'b1);
    look("train1", 32'h0000_0010, 1'b1, 32'h0000_0100);
    cnts("train1", 32'd1, 32'd1);

    repeat (3) upd(32'h0000_0010, 1'b1, 32'h0000_0100, 1'b0);
    look("sat11", 32'h0000_0010, 1'b1, 32'h0000_0100);
    upd(32'h0000_0010, 1'b0, 32'h0, 1'b0);
    look("nt1", 32'h0000_0010, 1'b1, 32'h0000_0100);
    upd(32'h0000_0010, 1'b0, 32'h0, 1'b1);
    look("nt2", 32'h0000_0010, 1'b0, 32'h0000_0014);
    cnts("nt2", 32'd6, 32'd2);

    // Aliasing: 0x10 and 0x50 share index 4 with different tags
    upd(32'h0000_0010, 1'b1, 32'h0000_0100, 1'b0);
    look("alias_own", 32'h0000_0010, 1'b1, 32'h0000_0100);
    look("alias_miss", 32'h0000_0050, 1'b0, 32'h0000_0054);
    upd(32'h0000_0050, 1'b1, 32'h0000_0200, 1'b0);
    look("alias_new", 32'h0000_0050, 1'b1, 32'h0000_0200);
    look("alias_old", 32'h0000_0010, 1'b0, 32'h0000_0014);

    // Short reset pulse between edges
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    look("pulse_a", 32'h0000_0010, 1'b0, 32'h0000_0014);
    look("pulse_b", 32'h0000_0050, 1'b0, 32'h0000_0054);
    cnts("pulse", 32'd0, 32'd0);

    // Reset held across an edge with upd_en high: update must be discarded
    upd_pc = 32'h0000_0030; upd_taken = 1'b1; upd_target = 32'h0000_0300;
    upd_mispred = 1'b1; upd_en = 1'b1; rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    upd_en = 1'b0; rst_n = 1'b1;
    look("rst_upd", 32'h0000_0030, 1'b0, 32'h0000_0034);
    cnts("rst_upd", 32'd0, 32'd0);

    // Same-cycle lookup and update: lookup sees pre-update state
    if_pc = 32'h0000_0020;
    upd_pc = 32'h0000_0020; upd_taken = 1'b1; upd_target = 32'h0000_0080;
    upd_mispred = 1'b0; upd_en = 1'b1;
    look("haz_same", 32'h0000_0020, 1'b0, 32'h0000_0024);
    @(posedge clk);
    @(negedge clk);
    upd_en = 1'b0;
    look("haz_next", 32'h0000_0020, 1'b1, 32'h0000_0080);
    // One not-taken from 10 lands on 01, proving reset counter value was 01
    upd(32'h0000_0020, 1'b0, 32'h0, 1'b0);
    look("haz_nt", 32'h0000_0020, 1'b0, 32'h0000_0024);

    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Saturating branch counter from a preloaded value
    force dut.br_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_q;
    cnts("preload", 32'hFFFF_FFFE, 32'd0);
    repeat (3) upd(32'h0000_0040, 1'b0, 32'h0, 1'b1);
    cnts("sat", 32'hFFFF_FFFF, 32'd3);
    look("sat_nt", 32'h0000_0040, 1'b0, 32'h0000_0044);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
